// File: rtl/exwb_arbiter.sv
// Writeback arbiter: buffers the four execution-unit result ports in per-unit FIFOs
// and broadcasts at most one result per cycle on the common result bus, round-robin.
module exwb_arbiter #(
   parameter int unsigned      DATA_W      = 32,
   parameter int unsigned      TAG_W       = 4,
   parameter logic [TAG_W-1:0] TAG_INVALID = '1,
   parameter int unsigned      DEPTH       = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [TAG_W-1:0]  alu_target,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [TAG_W-1:0]  fwd_target,
   input  logic [DATA_W-1:0] fwd_result,
   input  logic [TAG_W-1:0]  jump_target,
   input  logic [DATA_W-1:0] jump_ori_pc,
   input  logic [DATA_W-1:0] jump_next_pc,
   input  logic [TAG_W-1:0]  br_target,
   input  logic [DATA_W-1:0] br_next_pc,
   input  logic              br_cmp_res,
   output logic [TAG_W-1:0]  cdb_tag,
   output logic [DATA_W-1:0] cdb_val,
   output logic [DATA_W-1:0] cdb_next_pc,
   output logic              cdb_cmp_res,
   output logic [1:0]        cdb_kind,
   output logic [3:0]        busy,
   output logic              overflow
);

   localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned   CW       = PW + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_BUSY = CW'(DEPTH - 1);

   logic [TAG_W-1:0]  in_tag [4];
   logic [DATA_W-1:0] in_val [4];
   logic [DATA_W-1:0] in_npc [4];
   logic              in_cmp [4];

   logic [TAG_W-1:0]  tag_mem_q [4][DEPTH];
   logic [DATA_W-1:0] val_mem_q [4][DEPTH];
   logic [DATA_W-1:0] npc_mem_q [4][DEPTH];
   logic              cmp_mem_q [4][DEPTH];

   logic [PW-1:0] wr_ptr_q [4];
   logic [PW-1:0] wr_ptr_d [4];
   logic [PW-1:0] rd_ptr_q [4];
   logic [PW-1:0] rd_ptr_d [4];
   logic [CW-1:0] cnt_q    [4];
   logic [CW-1:0] cnt_d    [4];

   logic [1:0] rr_q, rr_d;
   logic       overflow_q, overflow_d;

   logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
   logic [DATA_W-1:0] cdb_val_q, cdb_val_d;
   logic [DATA_W-1:0] cdb_npc_q, cdb_npc_d;
   logic              cdb_cmp_q, cdb_cmp_d;
   logic [1:0]        cdb_kind_q, cdb_kind_d;

   logic [3:0] req;
   logic [3:0] push_vld;
   logic [3:0] full;
   logic [3:0] pop;
   logic [3:0] push_ok;
   logic       gnt_vld;
   logic [1:0] gnt_idx;

   // Branch entries carry no result value; ALU/forwarder carry no PC or outcome.
   always_comb begin
      in_tag[0] = alu_target;  in_val[0] = alu_result;  in_npc[0] = '0;           in_cmp[0] = 1'b0;
      in_tag[1] = fwd_target;  in_val[1] = fwd_result;  in_npc[1] = '0;           in_cmp[1] = 1'b0;
      in_tag[2] = jump_target; in_val[2] = jump_ori_pc; in_npc[2] = jump_next_pc; in_cmp[2] = 1'b0;
      in_tag[3] = br_target;   in_val[3] = '0;          in_npc[3] = br_next_pc;   in_cmp[3] = br_cmp_res;
   end

   always_comb begin
      req      = '0;
      push_vld = '0;
      full     = '0;
      busy     = '0;
      for (int i = 0; i < 4; i++) begin
         req[i]      = (cnt_q[i] != '0);
         full[i]     = (cnt_q[i] == CNT_FULL);
         busy[i]     = (cnt_q[i] >= CNT_BUSY);
         push_vld[i] = (in_tag[i] != TAG_INVALID);
      end
   end

   // Scan downwards so the requester closest to rr (smallest offset) wins.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = rr_q;
      for (int k = 3; k >= 0; k--) begin
         if (req[rr_q + 2'(k)]) begin
            gnt_vld = 1'b1;
            gnt_idx = rr_q + 2'(k);
         end
      end
   end

   always_comb begin
      pop        = '0;
      push_ok    = '0;
      overflow_d = overflow_q;
      for (int i = 0; i < 4; i++) begin
         pop[i]     = gnt_vld && (gnt_idx == 2'(i)) && !flush;
         push_ok[i] = push_vld[i] && (!full[i] || pop[i]) && !flush;
         if (push_vld[i] && full[i] && !pop[i] && !flush) begin
            overflow_d = 1'b1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         wr_ptr_d[i] = wr_ptr_q[i] + PW'(push_ok[i]);
         rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop[i]);
         cnt_d[i]    = cnt_q[i] + CW'(push_ok[i]) - CW'(pop[i]);
         if (flush) begin
            wr_ptr_d[i] = '0;
            rd_ptr_d[i] = '0;
            cnt_d[i]    = '0;
         end
      end
      rr_d = rr_q;
      if (flush) begin
         rr_d = 2'd0;
      end else if (gnt_vld) begin
         rr_d = gnt_idx + 2'd1;
      end
   end

   always_comb begin
      cdb_tag_d  = TAG_INVALID;
      cdb_val_d  = '0;
      cdb_npc_d  = '0;
      cdb_cmp_d  = 1'b0;
      cdb_kind_d = 2'd0;
      if (gnt_vld && !flush) begin
         cdb_tag_d  = tag_mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
         cdb_val_d  = val_mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
         cdb_npc_d  = npc_mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
         cdb_cmp_d  = cmp_mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
         cdb_kind_d = gnt_idx;
      end
   end

   // Entry storage needs no reset; validity is tracked by the counts.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (push_ok[i]) begin
            tag_mem_q[i][wr_ptr_q[i]] <= in_tag[i];
            val_mem_q[i][wr_ptr_q[i]] <= in_val[i];
            npc_mem_q[i][wr_ptr_q[i]] <= in_npc[i];
            cmp_mem_q[i][wr_ptr_q[i]] <= in_cmp[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            cnt_q[i]    <= '0;
         end
         rr_q       <= 2'd0;
         overflow_q <= 1'b0;
         cdb_tag_q  <= TAG_INVALID;
         cdb_val_q  <= '0;
         cdb_npc_q  <= '0;
         cdb_cmp_q  <= 1'b0;
         cdb_kind_q <= 2'd0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            wr_ptr_q[i] <= wr_ptr_d[i];
            rd_ptr_q[i] <= rd_ptr_d[i];
            cnt_q[i]    <= cnt_d[i];
         end
         rr_q       <= rr_d;
         overflow_q <= overflow_d;
         cdb_tag_q  <= cdb_tag_d;
         cdb_val_q  <= cdb_val_d;
         cdb_npc_q  <= cdb_npc_d;
         cdb_cmp_q  <= cdb_cmp_d;
         cdb_kind_q <= cdb_kind_d;
      end
   end

   assign cdb_tag     = cdb_tag_q;
   assign cdb_val     = cdb_val_q;
   assign cdb_next_pc = cdb_npc_q;
   assign cdb_cmp_res = cdb_cmp_q;
   assign cdb_kind    = cdb_kind_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_exwb_arbiter.sv
// Bench for exwb_arbiter: directed scenarios then random traffic, all checked each
// cycle against a queue-based reference model of the writeback buffering and arbitration.
module tb_exwb_arbiter;

   localparam int         DEPTH = 4;
   localparam logic [3:0] TINV  = 4'hF;

   logic        clk;
   logic        rst, flush;
   logic [3:0]  alu_target, fwd_target, jump_target, br_target;
   logic [31:0] alu_result, fwd_result, jump_ori_pc, jump_next_pc, br_next_pc;
   logic        br_cmp_res;
   logic [3:0]  cdb_tag;
   logic [31:0] cdb_val, cdb_next_pc;
   logic        cdb_cmp_res;
   logic [1:0]  cdb_kind;
   logic [3:0]  busy;
   logic        overflow;

   exwb_arbiter dut (
      .clk(clk), .rst(rst), .flush(flush),
      .alu_target(alu_target), .alu_result(alu_result),
      .fwd_target(fwd_target), .fwd_result(fwd_result),
      .jump_target(jump_target), .jump_ori_pc(jump_ori_pc), .jump_next_pc(jump_next_pc),
      .br_target(br_target), .br_next_pc(br_next_pc), .br_cmp_res(br_cmp_res),
      .cdb_tag(cdb_tag), .cdb_val(cdb_val), .cdb_next_pc(cdb_next_pc),
      .cdb_cmp_res(cdb_cmp_res), .cdb_kind(cdb_kind), .busy(busy), .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  tag;
      logic [31:0] val;
      logic [31:0] npc;
      logic        cmp;
   } ent_t;

   ent_t q[4][$];
   int   m_rr;
   logic m_ovf;
   ent_t e_cdb;
   int   e_kind;

   logic        s_rst, s_flush, s_gate;
   logic [3:0]  s_tag [4];
   logic [31:0] s_alu, s_fwd, s_jori, s_jnpc, s_bnpc;
   logic        s_bcmp;

   int total = 0;
   int bad   = 0;
   int alu_bcast = 0;

   task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", nm, obs, expv);
      end
   endtask

   task automatic idle_stim();
      s_rst = 1'b0; s_flush = 1'b0; s_gate = 1'b0;
      for (int i = 0; i < 4; i++) s_tag[i] = TINV;
      s_alu  = $urandom; s_fwd  = $urandom; s_jori = $urandom;
      s_jnpc = $urandom; s_bnpc = $urandom; s_bcmp = 1'($urandom);
   endtask

   function automatic ent_t idle_ent();
      ent_t e;
      e.tag = TINV; e.val = '0; e.npc = '0; e.cmp = 1'b0;
      return e;
   endfunction

   // One cycle: check outputs from the previous edge, drive inputs, advance the model.
   task automatic step();
      logic [3:0] t [4];
      logic [3:0] e_busy;
      ent_t       ne;
      int         g;
      @(negedge clk);
      e_busy = '0;
      for (int i = 0; i < 4; i++) e_busy[i] = (q[i].size() >= DEPTH - 1);
      chk("cdb_tag",  64'(cdb_tag),     64'(e_cdb.tag));
      chk("cdb_val",  64'(cdb_val),     64'(e_cdb.val));
      chk("cdb_npc",  64'(cdb_next_pc), 64'(e_cdb.npc));
      chk("cdb_cmp",  64'(cdb_cmp_res), 64'(e_cdb.cmp));
      chk("cdb_kind", 64'(cdb_kind),    64'(e_kind));
      chk("busy",     64'(busy),        64'(e_busy));
      chk("overflow", 64'(overflow),    64'(m_ovf));
      if (e_cdb.tag != TINV && e_kind == 0) alu_bcast++;

      for (int i = 0; i < 4; i++) t[i] = (s_gate && busy[i]) ? TINV : s_tag[i];
      rst = s_rst; flush = s_flush;
      alu_target = t[0]; alu_result = s_alu;
      fwd_target = t[1]; fwd_result = s_fwd;
      jump_target = t[2]; jump_ori_pc = s_jori; jump_next_pc = s_jnpc;
      br_target = t[3]; br_next_pc = s_bnpc; br_cmp_res = s_bcmp;

      e_cdb  = idle_ent();
      e_kind = 0;
      if (s_rst || s_flush) begin
         for (int i = 0; i < 4; i++) q[i].delete();
         m_rr = 0;
         if (s_rst) m_ovf = 1'b0;
      end else begin
         g = -1;
         for (int k = 0; k < 4; k++) begin
            if (g < 0 && q[(m_rr + k) % 4].size() > 0) g = (m_rr + k) % 4;
         end
         if (g >= 0) begin
            e_cdb  = q[g].pop_front();
            e_kind = g;
            m_rr   = (g + 1) % 4;
         end
         for (int i = 0; i < 4; i++) begin
            if (t[i] != TINV) begin
               ne.tag = t[i];
               ne.val = (i == 0) ? s_alu : (i == 1) ? s_fwd : (i == 2) ? s_jori : 32'd0;
               ne.npc = (i == 2) ? s_jnpc : (i == 3) ? s_bnpc : 32'd0;
               ne.cmp = (i == 3) ? s_bcmp : 1'b0;
               if (q[i].size() < DEPTH) q[i].push_back(ne);
               else m_ovf = 1'b1;
            end
         end
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int c = 0; c < n; c++) begin
         idle_stim();
         step();
      end
   endtask

   initial begin
      idle_stim();
      rst = 1'b1; flush = 1'b0;
      alu_target = TINV; fwd_target = TINV; jump_target = TINV; br_target = TINV;
      alu_result = '0; fwd_result = '0; jump_ori_pc = '0; jump_next_pc = '0;
      br_next_pc = '0; br_cmp_res = 1'b0;
      m_rr = 0; m_ovf = 1'b0; e_cdb = idle_ent(); e_kind = 0;

      // reset
      idle_stim(); s_rst = 1'b1; step(); step();
      idle_cycles(2);

      // single ALU result: visible two cycles later, then idle
      idle_stim(); s_tag[0] = 4'd3; s_alu = 32'h1234; step();
      idle_cycles(4);

      // four simultaneous results from rr=0
      idle_stim(); s_flush = 1'b1; step();
      idle_stim();
      s_tag[0] = 4'd1; s_tag[1] = 4'd2; s_tag[2] = 4'd3; s_tag[3] = 4'd4;
      s_bcmp = 1'b1; s_bnpc = 32'h0000_8000; s_jnpc = 32'h0000_4000;
      step();
      idle_cycles(7);

      // fairness: ALU and branch every cycle, honouring busy
      for (int c = 0; c < 8; c++) begin
         idle_stim(); s_gate = 1'b1;
         s_tag[0] = 4'(c); s_tag[3] = 4'(c + 8);
         step();
      end
      idle_cycles(10);
      chk("fair_no_ovf", 64'(overflow), 64'd0);

      // overflow: all units push every cycle, ALU starved below its arrival rate
      alu_bcast = 0;
      idle_stim(); s_flush = 1'b1; step();
      for (int c = 0; c < 7; c++) begin
         idle_stim();
         s_tag[0] = 4'(c); s_tag[1] = 4'(c + 1); s_tag[2] = 4'(c + 2); s_tag[3] = 4'(c + 3);
         step();
      end
      idle_cycles(30);
      chk("ovf_set", 64'(overflow), 64'd1);
      chk("ovf_alu_count", 64'(alu_bcast), 64'(q[0].size() == 0 ? 6 : 0));

      // flush mid-stream with a new jump result in the flush cycle
      idle_stim(); s_tag[1] = 4'd5; s_tag[2] = 4'd6; s_tag[3] = 4'd7; step();
      idle_stim(); s_flush = 1'b1; s_tag[2] = 4'd9; step();
      idle_cycles(6);

      // reset mid-operation with overflow set, then single-result latency
      idle_stim(); s_tag[0] = 4'd2; s_tag[1] = 4'd3; step();
      idle_stim(); s_rst = 1'b1; s_tag[3] = 4'd1; step();
      idle_stim(); s_tag[0] = 4'd8; s_alu = 32'hCAFE_F00D; step();
      idle_cycles(4);

      // random traffic
      for (int c = 0; c < 800; c++) begin
         idle_stim();
         s_rst   = ($urandom_range(0, 199) == 0);
         s_flush = ($urandom_range(0, 39) == 0);
         s_gate  = ($urandom_range(0, 1) == 0);
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 2) != 0) s_tag[i] = 4'($urandom_range(0, 14));
         end
         step();
      end
      idle_cycles(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
